// File: rtl/mips_instr_rom_mon.sv
// Boot-ROM model with CPU run monitor: loadable instruction store, combinational fetch port,
// and a LOAD/RUN/HALTED/TIMEOUT supervisor. Define INSTR_ROM_FETCH_COUNT_EN to build fetch_count.
module mips_instr_rom_mon #(
   parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
   parameter int          DEPTH     = 64,
   parameter int          TIMEOUT   = 100,
   parameter int          BYTE_SWAP = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_index,
   input  logic [31:0]              load_data,
   input  logic                     run_go,
   input  logic [31:0]              instr_address,
   output logic [31:0]              instr_readdata,
   input  logic                     active,
   input  logic [31:0]              register_v0,
   output logic [1:0]               state,
   output logic [31:0]              result,
   output logic [31:0]              cycles,
   output logic                     oob_fetch,
   output logic                     misaligned,
   output logic [31:0]              fetch_count
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HALTED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] rom_q [DEPTH];
   logic [31:0] rom_d [DEPTH];
   logic [31:0] result_q, result_d;
   logic [31:0] cycles_q, cycles_d;
   logic        oob_q, oob_d;
   logic        mis_q, mis_d;

   logic [29:0]   word_off;
   logic          in_window;
   logic [IW-1:0] rd_index;
   logic [31:0]   rd_word;
   logic          halt_req;
   logic          enter_run;

   // Fetch path: the subtraction wraps for addresses below BASE_ADDR, hence the explicit lower bound.
   always_comb begin
      word_off  = 30'((instr_address - BASE_ADDR) >> 2);
      in_window = (instr_address >= BASE_ADDR) && (word_off < 30'(DEPTH));
      rd_index  = word_off[IW-1:0];
      rd_word   = rom_q[rd_index];
      if (!in_window)
         instr_readdata = '0;
      else if (BYTE_SWAP != 0)
         instr_readdata = {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};
      else
         instr_readdata = rd_word;
   end

   assign halt_req  = !active && (instr_address == '0);
   assign enter_run = (state_q != ST_RUN) && run_go;

   // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_d  = state_q;
      rom_d    = rom_q;
      result_d = result_q;
      cycles_d = cycles_q;
      oob_d    = oob_q;
      mis_d    = mis_q;
      unique case (state_q)
         ST_LOAD: begin
            if (load_en) rom_d[load_index] = load_data;
         end
         ST_RUN: begin
            cycles_d = cycles_q + 32'd1;
            if (!in_window && !halt_req) oob_d = 1'b1;
            if (instr_address[1:0] != 2'b00) mis_d = 1'b1;
            if (halt_req) begin
               result_d = register_v0;
               state_d  = ST_HALTED;
            end else if (cycles_d == 32'(TIMEOUT)) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: ;
      endcase
      if (enter_run) begin
         state_d  = ST_RUN;
         result_d = '0;
         cycles_d = '0;
         oob_d    = 1'b0;
         mis_d    = 1'b0;
      end
   end

   // NOTE: the ROM is built from resettable flops because reset must zero every word at once;
   // a plain RAM macro could not honour that.
   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_LOAD;
         result_q <= '0;
         cycles_q <= '0;
         oob_q    <= 1'b0;
         mis_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) rom_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         cycles_q <= cycles_d;
         oob_q    <= oob_d;
         mis_q    <= mis_d;
         rom_q    <= rom_d;
      end
   end

`ifdef INSTR_ROM_FETCH_COUNT_EN
   logic [31:0] fcnt_q, fcnt_d;
   logic [31:0] prev_addr_q, prev_addr_d;
   logic        first_q, first_d;

   // first_q makes the opening RUN edge count even if it repeats the last address of a previous run.
   always_comb begin
      fcnt_d      = fcnt_q;
      prev_addr_d = prev_addr_q;
      first_d     = first_q;
      if (state_q == ST_RUN) begin
         if (in_window && (first_q || instr_address != prev_addr_q)) fcnt_d = fcnt_q + 32'd1;
         prev_addr_d = instr_address;
         first_d     = 1'b0;
      end
      if (enter_run) begin
         fcnt_d  = '0;
         first_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fcnt_q      <= '0;
         prev_addr_q <= '0;
         first_q     <= 1'b1;
      end else begin
         fcnt_q      <= fcnt_d;
         prev_addr_q <= prev_addr_d;
         first_q     <= first_d;
      end
   end

   assign fetch_count = fcnt_q;
`else
   assign fetch_count = '0;
`endif

   assign state      = state_q;
   assign result     = result_q;
   assign cycles     = cycles_q;
   assign oob_fetch  = oob_q;
   assign misaligned = mis_q;
endmodule

// File: tb/tb_mips_instr_rom_mon.sv
// Directed bench for mips_instr_rom_mon with default parameters (BYTE_SWAP=1, DEPTH=64, TIMEOUT=100).
module tb_mips_instr_rom_mon;
   localparam int IW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [IW-1:0] load_index;
   logic [31:0]   load_data;
   logic          run_go;
   logic [31:0]   instr_address;
   logic [31:0]   instr_readdata;
   logic          active;
   logic [31:0]   register_v0;
   logic [1:0]    state;
   logic [31:0]   result;
   logic [31:0]   cycles;
   logic          oob_fetch;
   logic          misaligned;
   logic [31:0]   fetch_count;

   int checks = 0;
   int errors = 0;

`ifdef INSTR_ROM_FETCH_COUNT_EN
   localparam logic [31:0] EXP_FCNT = 32'd2;
`else
   localparam logic [31:0] EXP_FCNT = 32'd0;
`endif

   mips_instr_rom_mon dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_index     (load_index),
      .load_data      (load_data),
      .run_go         (run_go),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .active         (active),
      .register_v0    (register_v0),
      .state          (state),
      .result         (result),
      .cycles         (cycles),
      .oob_fetch      (oob_fetch),
      .misaligned     (misaligned),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; load_en = 1'b0; load_index = '0; load_data = '0; run_go = 1'b0;
      instr_address = 32'hBFC00000; active = 1'b1; register_v0 = '0;
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_cycles", cycles, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {30'd0, oob_fetch, misaligned}, 32'd0);
      check("rst_fcnt", fetch_count, 32'd0);
      check("rst_rom0", instr_readdata, 32'd0);
      tick();
      reset = 1'b1;

      // Load program; each word becomes visible the cycle after its write edge.
      load_en = 1'b1; load_index = 6'd0; load_data = 32'h24420001;
      #1 check("pre_write", instr_readdata, 32'd0);
      tick();
      check("load_state", 32'(state), 32'd0);
      check("rd_bfc00000", instr_readdata, 32'h01004224);
      load_index = 6'd1; load_data = 32'h00000008;
      tick();
      instr_address = 32'hBFC00004;
      #1 check("rd_bfc00004", instr_readdata, 32'h08000000);
      load_index = 6'd2; load_data = 32'h24420001;
      tick();
      load_index = 6'd3; load_data = 32'h24000001; run_go = 1'b1;
      tick();
      load_en = 1'b0; run_go = 1'b0;
      check("go_state", 32'(state), 32'd1);
      check("go_cycles", cycles, 32'd0);
      instr_address = 32'hBFC0000C;
      #1 check("rd_word3", instr_readdata, 32'h01000024);

      // Halt on RUN edge 5; run_go on edge 2 must be ignored.
      for (int i = 0; i < 4; i++) begin
         instr_address = 32'hBFC00000 + 32'(4 * i);
         run_go = (i == 1);
         tick();
      end
      run_go = 1'b0;
      check("run4_state", 32'(state), 32'd1);
      check("run4_cycles", cycles, 32'd4);
      active = 1'b0; instr_address = 32'h0; register_v0 = 32'd2;
      tick();
      check("halt_state", 32'(state), 32'd2);
      check("halt_result", result, 32'd2);
      check("halt_cycles", cycles, 32'd5);
      check("halt_flags", {30'd0, oob_fetch, misaligned}, 32'd0);
      #1 check("rd_addr0", instr_readdata, 32'd0);

      // HALTED holds everything and ignores load_en.
      active = 1'b1; register_v0 = 32'h99; instr_address = 32'hBFC00000;
      load_en = 1'b1; load_index = 6'd0; load_data = 32'hFFFFFFFF;
      tick(); tick();
      load_en = 1'b0;
      check("hold_state", 32'(state), 32'd2);
      check("hold_cycles", cycles, 32'd5);
      check("hold_result", result, 32'd2);
      check("no_load_halted", instr_readdata, 32'h01004224);

      // Timeout after 100 RUN edges.
      run_go = 1'b1;
      tick();
      run_go = 1'b0;
      check("rerun_state", 32'(state), 32'd1);
      check("rerun_cycles", cycles, 32'd0);
      check("rerun_result", result, 32'd0);
      repeat (99) tick();
      check("to99_state", 32'(state), 32'd1);
      check("to99_cycles", cycles, 32'd99);
      tick();
      check("to_state", 32'(state), 32'd3);
      check("to_cycles", cycles, 32'd100);
      check("to_result", result, 32'd0);
      tick();
      check("to_hold", cycles, 32'd100);

      // Out-of-window and misaligned fetches, both sticky.
      run_go = 1'b1;
      tick();
      run_go = 1'b0;
      instr_address = 32'hBFC00100;
      #1 check("rd_oob", instr_readdata, 32'd0);
      tick();
      check("oob_set", {30'd0, oob_fetch, misaligned}, 32'd2);
      instr_address = 32'hBFC00002;
      #1 check("rd_mis", instr_readdata, 32'h01004224);
      tick();
      check("mis_set", {30'd0, oob_fetch, misaligned}, 32'd3);
      instr_address = 32'hBFC00004;
      tick();
      check("flags_sticky", {30'd0, oob_fetch, misaligned}, 32'd3);
      active = 1'b0; instr_address = 32'h0; register_v0 = 32'h1234;
      tick();
      check("halt2_state", 32'(state), 32'd2);
      check("halt2_flags", {30'd0, oob_fetch, misaligned}, 32'd3);
      active = 1'b1; instr_address = 32'hBFC00000; run_go = 1'b1;
      tick();
      run_go = 1'b0;
      check("flags_clear", {30'd0, oob_fetch, misaligned}, 32'd0);

      // Halt on the first RUN edge: address 0 must not flag oob.
      active = 1'b0; instr_address = 32'h0; register_v0 = 32'hCAFE;
      tick();
      check("halt3_state", 32'(state), 32'd2);
      check("halt3_result", result, 32'hCAFE);
      check("halt3_cycles", cycles, 32'd1);
      check("halt3_oob", {31'd0, oob_fetch}, 32'd0);

      // Halt and timeout on the same edge resolve to HALTED.
      active = 1'b1; instr_address = 32'hBFC00000; run_go = 1'b1;
      tick();
      run_go = 1'b0;
      repeat (99) tick();
      active = 1'b0; instr_address = 32'h0; register_v0 = 32'd7;
      tick();
      check("both_state", 32'(state), 32'd2);
      check("both_result", result, 32'd7);
      check("both_cycles", cycles, 32'd100);

      // Fetch counting, then asynchronous reset mid-RUN at cycle 7.
      active = 1'b1; instr_address = 32'hBFC00000; run_go = 1'b1;
      tick();
      run_go = 1'b0;
      instr_address = 32'hBFC00000; tick();
      instr_address = 32'hBFC00000; tick();
      instr_address = 32'hBFC00004; tick();
      check("fetch_count", fetch_count, EXP_FCNT);
      for (int i = 0; i < 4; i++) begin
         instr_address = 32'hBFC00008 + 32'(4 * i);
         tick();
      end
      check("pre_rst_cycles", cycles, 32'd7);
      check("pre_rst_state", 32'(state), 32'd1);
      instr_address = 32'hBFC00000;
      #1 check("pre_rst_rom", instr_readdata, 32'h01004224);
      reset = 1'b0;
      #1;
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_cycles", cycles, 32'd0);
      check("mid_rst_fcnt", fetch_count, 32'd0);
      check("mid_rst_rom", instr_readdata, 32'd0);
      tick();
      check("rst_held_state", 32'(state), 32'd0);
      reset = 1'b1;
      tick();
      check("post_rst_state", 32'(state), 32'd0);
      check("post_rst_cycles", cycles, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_instr_rom_mon.md
MIPS_INSTR_ROM_MON -- requirements
Module: mips_instr_rom_mon

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- BASE_ADDR, 32'hBFC00000, byte address of ROM word 0
- DEPTH, 64, ROM size in 32-bit words, power of two, 4..4096
- TIMEOUT, 100, maximum RUN cycles before abort, >= 2
- BYTE_SWAP, 1, 1 = present words byte-reversed to the CPU, 0 = as stored
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  write load_data into ROM word load_index
- load_index  in  clog2(DEPTH)  ROM word index for load
- load_data  in  32  instruction word in listing (big-endian) order
- run_go  in  1  start/restart program run
- instr_address  in  32  CPU fetch address
- instr_readdata  out  32  fetched word to CPU
- active  in  1  CPU active flag
- register_v0  in  32  CPU v0 value
- state  out  2  0=LOAD, 1=RUN, 2=HALTED, 3=TIMEOUT
- result  out  32  v0 captured at halt
- cycles  out  32  RUN cycles elapsed
- oob_fetch  out  1  sticky: RUN fetch outside ROM window
- misaligned  out  1  sticky: RUN fetch with instr_address[1:0] != 0
- fetch_count  out  32  in-window RUN fetches (see REQ-017)

Function
REQ-003 Read path SHALL be combinational: index = (instr_address - BASE_ADDR) >> 2; in-window iff instr_address >= BASE_ADDR and index < DEPTH.
REQ-004 In-window read SHALL return the stored word, byte-reversed ({d[7:0],d[15:8],d[23:16],d[31:24]}) when BYTE_SWAP=1; address bits [1:0] ignored for indexing.
REQ-005 Out-of-window read SHALL return 32'h00000000 (NOP) in every state.
REQ-006 In LOAD, load_en=1 SHALL write load_data to the indexed word at the rising edge; the new word is readable from the following cycle; load_en outside LOAD is ignored.
REQ-007 FSM transitions: LOAD -> RUN on run_go=1; HALTED or TIMEOUT -> RUN on run_go=1; RUN ignores run_go.
REQ-008 load_en and run_go together in LOAD SHALL perform the write and enter RUN on the same edge.
REQ-009 Entering RUN SHALL clear cycles, result, oob_fetch, misaligned and fetch_count; ROM contents are kept.
REQ-010 Each edge in RUN SHALL increment cycles by 1, including the exiting edge.
REQ-011 Halt: edge in RUN with active=0 and instr_address=0 SHALL capture register_v0 into result and enter HALTED.
REQ-012 Timeout: edge in RUN where cycles+1 = TIMEOUT and no halt SHALL enter TIMEOUT; result stays 0.
REQ-013 Halt and timeout on the same edge SHALL resolve to HALTED.
REQ-014 oob_fetch/misaligned SHALL set on any RUN edge with the condition true and hold until re-entry to RUN or reset; address 0 during halt does not set oob_fetch.
REQ-015 In HALTED/TIMEOUT all counters, flags and result SHALL hold.

Reset
REQ-016 reset=0 SHALL asynchronously force state=LOAD, every ROM word=0, and result, cycles, fetch_count, oob_fetch, misaligned=0, including mid-RUN; outputs stay at these values until reset=1 and the next qualifying edge.

Configuration
REQ-017 Macro INSTR_ROM_FETCH_COUNT_EN: defined -> fetch_count increments on each RUN edge with an in-window address differing from the previous RUN-edge address (first RUN edge counts); undefined -> fetch_count is constant 0 and its counter is not built.

Verification
REQ-018 Bench SHALL cover:
- Load 24420001,00000008,24420001,24000001 at 0..3, run_go; fetch BFC00000 -> instr_readdata=01004224 (BYTE_SWAP=1), BFC00004 -> 08000000.
- CPU model drops active with instr_address=0, register_v0=2 on RUN edge 5 -> state=2, result=2, cycles=5.
- Never halt, TIMEOUT=100 -> state=3 after 100 RUN edges, cycles=100, result=0.
- Fetch BFC00100 (DEPTH=64) then BFC00002 -> instr_readdata=0, oob_fetch=1, misaligned=1; run_go from HALTED clears both.
- reset=0 mid-RUN at cycle 7 -> state=0, cycles=0, read of BFC00000 returns 0 immediately.
- With INSTR_ROM_FETCH_COUNT_EN, fetch sequence BFC00000,BFC00000,BFC00004 -> fetch_count=2; without macro -> 0.
